inst_fetch_unit: RTL

- Front end of the 3-bit-opcode CPU. Produces the instruction stream that the control decoder consumes.
- Generates sequential PCs and issues requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned words in a 2-entry FIFO and hands them to decode with a valid/ready handshake.
- Accepts redirects (taken branch / jump / jal) from execute; on a redirect it flushes buffered and in-flight instructions.

---
 rtl/inst_fetch_unit_if.sv | 34 +++
 rtl/inst_fetch_unit.sv | 111 +++++++++++
 2 files changed

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - fetch unit bus: imem request/response, redirect and decode handshake
interface inst_fetch_unit_if #(
  parameter int IW = 16,
  parameter int AW = 16
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic [2:0]    opcode;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output inst_valid, inst, inst_pc, opcode,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  inst_valid, inst, inst_pc, opcode,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - sequential instruction fetch with 2-entry buffer and redirect flush
module inst_fetch_unit #(
  parameter int            IW       = 16,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_unit_if.master bus
);
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] resp_pc_q, resp_pc_d;
  logic [2:0]    outstanding_q, outstanding_d;
  logic [2:0]    discard_q, discard_d;
  logic [IW-1:0] word_q [2];
  logic [AW-1:0] wpc_q [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [IW-1:0] hold_inst_q;
  logic [AW-1:0] hold_pc_q;
  logic          run_q;

  logic [2:0]    live;
  logic [2:0]    occupancy;
  logic          req, grant, rsp, push, pop;
  logic [IW-1:0] head_inst;
  logic [AW-1:0] head_pc;

  // A pop this cycle frees a slot in time for the response, giving one instruction per cycle.
  assign live      = outstanding_q - discard_q;
  assign pop       = (count_q != 2'd0) && bus.inst_ready;
  assign occupancy = live + {1'b0, count_q} - {2'b0, pop};
  assign req       = run_q && !bus.redirect && (occupancy < 3'd2) && (outstanding_q != 3'd7);
  assign grant     = req && bus.imem_gnt;
  assign rsp       = bus.imem_rvalid && (outstanding_q != 3'd0);
  assign push      = rsp && !bus.redirect && (discard_q == 3'd0);

  assign head_inst = (count_q != 2'd0) ? word_q[rd_ptr_q] : hold_inst_q;
  assign head_pc   = (count_q != 2'd0) ? wpc_q[rd_ptr_q]  : hold_pc_q;

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (count_q != 2'd0);
  assign bus.inst       = head_inst;
  assign bus.inst_pc    = head_pc;
  assign bus.opcode     = head_inst[IW-1:IW-3];

  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + {2'b0, grant} - {2'b0, rsp};
    discard_d     = discard_q;
    count_d       = count_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d      = rd_ptr_q ^ pop;
    wr_ptr_d      = wr_ptr_q ^ push;
    if (bus.redirect) begin
      pc_d      = bus.redirect_pc;
      resp_pc_d = bus.redirect_pc;
      // Everything still in flight after this cycle's response is stale.
      discard_d = outstanding_q - {2'b0, rsp};
      count_d   = 2'd0;
      rd_ptr_d  = 1'b0;
      wr_ptr_d  = 1'b0;
    end else begin
      if (grant) begin
        pc_d = pc_q + 1'b1;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 1'b1;
      end
      if (rsp && (discard_q != 3'd0)) begin
        discard_d = discard_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      hold_inst_q   <= '0;
      hold_pc_q     <= '0;
      run_q         <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        word_q[i] <= '0;
        wpc_q[i]  <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      hold_inst_q   <= head_inst;
      hold_pc_q     <= head_pc;
      run_q         <= 1'b1;
      if (push) begin
        word_q[wr_ptr_q] <= bus.imem_rdata;
        wpc_q[wr_ptr_q]  <= resp_pc_q;
      end
    end
  end
endmodule
